// File: rtl/mux_rr.sv
// mux_rr: round-robin CHANNELS:1 mux with a registered output stage, 1 cycle latency, 1 beat/cycle.
// in_ready follows the output register's free/draining state. MUX_RR_LOCK_EN adds packet lock (in_last/out_last).
module mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_RR_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last
`endif
);

  logic [SELW-1:0]     ptr;
  logic [SELW-1:0]     gidx;
  logic [SELW-1:0]     cand;
  logic [SELW:0]       sum;
  logic                found;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    sel_data;
  logic                load;
  logic                xfer;

`ifdef MUX_RR_LOCK_EN
  logic                locked;
  logic [SELW-1:0]     lock_ch;
`endif

  assign load     = (!out_valid || out_ready) && !rst;
  assign xfer     = load && found;
  assign in_ready = {CHANNELS{load}} & grant;

  // Search upward from ptr+1; sum is one bit wider so the wrap compare cannot overflow.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    sum   = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      sum = {1'b0, ptr} + (SELW+1)'(off);
      if (sum >= (SELW+1)'(CHANNELS))
        sum = sum - (SELW+1)'(CHANNELS);
      cand = sum[SELW-1:0];
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
`ifdef MUX_RR_LOCK_EN
    // Mid-packet the owner keeps the grant even while it idles.
    if (locked) begin
      found = in_valid[lock_ch];
      gidx  = lock_ch;
    end
`endif
    grant = '0;
    if (found)
      grant[gidx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (gidx == SELW'(i))
        sel_data = in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SELW'(CHANNELS-1);
`ifdef MUX_RR_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= gidx;
`ifdef MUX_RR_LOCK_EN
        out_last  <= in_last[gidx];
        if (in_last[gidx]) begin
          locked <= 1'b0;
          ptr    <= gidx;
        end else begin
          locked  <= 1'b1;
          lock_ch <= gidx;
        end
`else
        ptr       <= gidx;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// Directed bench for mux_rr; a negedge monitor pops hand-computed beats from a scoreboard queue.
module tb_mux_rr;

  localparam int W  = 16;
  localparam int CH = 4;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic [1:0]      out_sel;
  logic            out_valid;
  logic            out_ready = 1'b1;
`ifdef MUX_RR_LOCK_EN
  logic [CH-1:0]   in_last = '1;
  logic            out_last;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_RR_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [15:0] d, input logic l);
    exp_t e;
    e.sel  = 2'(sel);
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic set_data(input int ch, input logic [15:0] d);
    in_data[ch*W +: W] = d;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && q.size() != 0; i++)
      tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s drain: %0d beats still expected, 0 required", nm, q.size());
      q.delete();
    end
  endtask

  // Scoreboard monitor: every output transfer must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected beat: sel=%0d data=%h, none expected", out_sel, out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
`ifdef MUX_RR_LOCK_EN
        if (out_sel !== e.sel || out_data !== e.data || out_last !== e.last) begin
          bad++;
          $display("FAIL beat: got sel=%0d data=%h last=%b expected sel=%0d data=%h last=%b",
                   out_sel, out_data, out_last, e.sel, e.data, e.last);
        end
`else
        if (out_sel !== e.sel || out_data !== e.data) begin
          bad++;
          $display("FAIL beat: got sel=%0d data=%h expected sel=%0d data=%h",
                   out_sel, out_data, e.sel, e.data);
        end
`endif
      end
    end
  end

  initial begin
    // Reset state with every channel requesting.
    in_valid = 4'b1111;
    for (int i = 0; i < CH; i++) set_data(i, 16'h1000 + 16'(i));
    tick();
    tick();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data",  32'(out_data),  0);
    chk("rst out_sel",   32'(out_sel),   0);
    chk("rst in_ready",  32'(in_ready),  0);
`ifdef MUX_RR_LOCK_EN
    chk("rst out_last",  32'(out_last),  0);
`endif

    // All valid, out_ready high: 0,1,2,3,0 back to back.
    rst = 1'b0;
    #1;
    chk("rr first in_ready", 32'(in_ready), 32'b0001);
    chk("rr pre out_valid",  32'(out_valid), 0);
    push(0, 16'h1000, 1'b1);
    push(1, 16'h1001, 1'b1);
    push(2, 16'h1002, 1'b1);
    push(3, 16'h1003, 1'b1);
    push(0, 16'h1000, 1'b1);
    tick();
    chk("rr latency out_valid", 32'(out_valid), 1);
    repeat (4) tick();
    in_valid = '0;
    drain("rr");

    // Stall: only channel 2 valid, downstream not ready for 3 cycles.
    set_data(2, 16'hBEEF);
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    push(2, 16'hBEEF, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("stall out_valid", 32'(out_valid), 1);
      chk("stall out_data",  32'(out_data),  32'hBEEF);
      chk("stall out_sel",   32'(out_sel),   2);
      chk("stall in_ready",  32'(in_ready),  0);
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    drain("stall");

    // Wrap: grant 3, then 1 and 3 valid -> 1 then 3.
    set_data(1, 16'hA001);
    set_data(3, 16'hA003);
    in_valid = 4'b1000;
    push(3, 16'hA003, 1'b1);
    tick();
    in_valid = 4'b1010;
    push(1, 16'hA001, 1'b1);
    push(3, 16'hA003, 1'b1);
    tick();
    tick();
    in_valid = '0;
    drain("wrap");

    // Async reset mid-cycle discards a held beat.
    out_ready = 1'b0;
    set_data(1, 16'h1111);
    in_valid = 4'b0010;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 32'(out_valid), 0);
    chk("arst out_data",  32'(out_data),  0);
    chk("arst in_ready",  32'(in_ready),  0);
    set_data(1, 16'h2222);
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'b0010);
    push(1, 16'h2222, 1'b1);
    tick();
    in_valid = '0;
    drain("arst");

`ifdef MUX_RR_LOCK_EN
    // Packet lock: channel 0 sends 3 beats while channel 1 waits.
    set_data(1, 16'hD001);
    in_last  = 4'b1110;
    set_data(0, 16'hC000);
    in_valid = 4'b0011;
    #1;
    chk("lock first in_ready", 32'(in_ready), 32'b0001);
    push(0, 16'hC000, 1'b0);
    tick();
    in_valid = 4'b0010;
    #1;
    chk("lock idle in_ready", 32'(in_ready), 0);
    tick();
    in_valid = 4'b0011;
    set_data(0, 16'hC001);
    push(0, 16'hC001, 1'b0);
    tick();
    set_data(0, 16'hC002);
    in_last = 4'b1111;
    push(0, 16'hC002, 1'b1);
    tick();
    push(1, 16'hD001, 1'b1);
    tick();
    in_valid = '0;
    drain("lock");
`endif

    tick();
    chk("final queue empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
